aes_challenge_ctrl: RTL



---
 rtl/aes_challenge_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/aes_challenge_ctrl.sv
// Challenge-response wrapper around an AES-128 core: 16 RX bytes -> plaintext, ciphertext -> TX bytes MSB first.
// Build with AES_CHAL_CKSUM_EN defined to append an XOR-of-ciphertext checksum as a 17th TX byte.
module aes_challenge_ctrl #(
    parameter int unsigned RX_GAP_CYCLES      = 1000000,
    parameter int unsigned AES_TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic [127:0] aes_input_block,
    output logic         aes_start,
    input  logic         aes_done,
    input  logic [127:0] aes_output_block,
    output logic         busy,
    output logic         error,
    output logic         overrun
);
    localparam int GAP_W = $clog2(RX_GAP_CYCLES + 1);
    localparam int TO_W  = $clog2(AES_TIMEOUT_CYCLES + 1);
`ifdef AES_CHAL_CKSUM_EN
    localparam int RESP_BYTES = 17;
`else
    localparam int RESP_BYTES = 16;
`endif
    localparam int RESP_W = RESP_BYTES * 8;
    localparam logic [GAP_W-1:0] GAP_LIM  = GAP_W'(RX_GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RX_GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(AES_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {COLLECT, START, WAIT, SEND} state_t;

    state_t              state_q, state_d;
    logic [127:0]        chal_q, chal_d;
    logic [RESP_W-1:0]   resp_q, resp_d, resp_load;
    logic [3:0]          byte_cnt_q, byte_cnt_d;
    logic [4:0]          send_cnt_q, send_cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [TO_W-1:0]     tout_q, tout_d;
    logic                aes_start_q, aes_start_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;
    logic                overrun_q, overrun_d;

`ifdef AES_CHAL_CKSUM_EN
    function automatic logic [7:0] xor_bytes(input logic [127:0] v);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < 16; i++) x ^= v[8*i +: 8];
        return x;
    endfunction
    assign resp_load = {aes_output_block, xor_bytes(aes_output_block)};
`else
    assign resp_load = aes_output_block;
`endif

    always_comb begin
        state_d     = state_q;
        chal_d      = chal_q;
        resp_d      = resp_q;
        byte_cnt_d  = byte_cnt_q;
        send_cnt_d  = send_cnt_q;
        gap_d       = gap_q;
        tout_d      = tout_q;
        aes_start_d = 1'b0;
        tx_valid_d  = tx_valid_q;
        error_d     = error_q;
        overrun_d   = overrun_q;
        case (state_q)
            COLLECT: begin
                if (rx_valid) begin
                    chal_d     = {chal_q[119:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    gap_d      = '0;
                    if (byte_cnt_q == 4'd0) error_d = 1'b0;
                    if (byte_cnt_q == 4'd15) begin
                        state_d     = START;
                        aes_start_d = 1'b1;
                        tout_d      = '0;
                    end
                end else if (byte_cnt_q != 4'd0) begin
                    // Gap expiry discards the partial challenge; counter parks at its limit.
                    if (gap_q >= GAP_LAST) begin
                        byte_cnt_d = 4'd0;
                        gap_d      = GAP_LIM;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            START: begin
                // The timeout counter measures cycles since aes_start rose.
                tout_d  = tout_q + 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (aes_done) begin
                    resp_d     = resp_load;
                    send_cnt_d = 5'(RESP_BYTES);
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end else if (tout_q >= TO_LAST) begin
                    error_d = 1'b1;
                    tout_d  = '0;
                    state_d = COLLECT;
                end else begin
                    tout_d = tout_q + 1'b1;
                end
            end
            SEND: begin
                if (tx_valid_q && tx_ready) begin
                    resp_d     = {resp_q[RESP_W-9:0], 8'h00};
                    send_cnt_d = send_cnt_q - 5'd1;
                    if (send_cnt_q == 5'd1) begin
                        tx_valid_d = 1'b0;
                        state_d    = COLLECT;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
        if (rx_valid && state_q != COLLECT) overrun_d = 1'b1;
        busy_d = (state_d != COLLECT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= COLLECT;
            chal_q      <= '0;
            resp_q      <= '0;
            byte_cnt_q  <= '0;
            send_cnt_q  <= '0;
            gap_q       <= '0;
            tout_q      <= '0;
            aes_start_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            chal_q      <= chal_d;
            resp_q      <= resp_d;
            byte_cnt_q  <= byte_cnt_d;
            send_cnt_q  <= send_cnt_d;
            gap_q       <= gap_d;
            tout_q      <= tout_d;
            aes_start_q <= aes_start_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            overrun_q   <= overrun_d;
        end
    end

    assign tx_data         = resp_q[RESP_W-1 -: 8];
    assign tx_valid        = tx_valid_q;
    assign aes_input_block = chal_q;
    assign aes_start       = aes_start_q;
    assign busy            = busy_q;
    assign error           = error_q;
    assign overrun         = overrun_q;
endmodule
